edge_detect_multi: RTL and testbench
====================================

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 The block SHALL have parameter CH, default 8, number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (>=2).
REQ-003 The block SHALL have parameter FILT, default 4, consecutive stable cycles required to accept a level change (>=1).
REQ-004 The block SHALL have parameter CNT_W, default 8, width of each per-channel event counter.
REQ-005 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port d_in  input  CH  asynchronous raw channel inputs.
REQ-008 The block SHALL have port mode  input  2*CH  per-channel qualify mode, channel i in bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 The block SHALL have port clr  input  CH  per-channel synchronous clear of flag and counter.
REQ-010 The block SHALL have port pos_edge  output  CH  one-cycle pulse on accepted 0->1 transition.
REQ-011 The block SHALL have port neg_edge  output  CH  one-cycle pulse on accepted 1->0 transition.
REQ-012 The block SHALL have port evt_flag  output  CH  sticky qualified-event flag.
REQ-013 The block SHALL have port evt_cnt  output  CH*CNT_W  per-channel saturating event count, channel i in bits [(i+1)*CNT_W-1:i*CNT_W].
REQ-014 The block SHALL have port irq  output  1  OR-reduction of evt_flag.

Function
REQ-015 Each channel SHALL pass d_in[i] through a SYNC_STAGES flop chain; the last stage is the synchronised level s.
REQ-016 Each channel SHALL hold a filtered level f and counter fc; per edge: s==f -> fc<=0; s!=f and fc==FILT-1 -> f<=s, fc<=0; s!=f otherwise -> fc<=fc+1.
REQ-017 A pulse on s shorter than FILT cycles SHALL leave f unchanged and produce no edge, flag or count.
REQ-018 A registered copy f_d SHALL follow f by one cycle; pos_edge[i] = f & ~f_d, neg_edge[i] = ~f & f_d, each exactly one cycle wide.
REQ-019 Latency SHALL be fixed: a d_in change settled before edge E1 sets f at edge E(SYNC_STAGES+FILT); the pulse is high for the following cycle (default: after edge E6).
REQ-020 pos_edge/neg_edge SHALL be independent of mode.
REQ-021 A qualifying event SHALL be pos_edge with mode bit0=1, or neg_edge with mode bit1=1; mode is sampled in the pulse cycle.
REQ-022 On a qualifying event evt_flag[i] SHALL be 1 and evt_cnt[i] SHALL have incremented from the next edge onward.
REQ-023 evt_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clr[i] alone SHALL zero evt_flag[i] and evt_cnt[i] at the next edge.
REQ-025 clr[i] coincident with a qualifying event SHALL give evt_flag[i]=1 and evt_cnt[i]=1 (event not lost).
REQ-026 irq SHALL be combinational OR of evt_flag, with no additional latency.
REQ-027 Channels SHALL be fully independent; simultaneous events on any channel set SHALL all be recorded.

Reset
REQ-028 reset SHALL asynchronously clear all sync stages, f, f_d, fc, evt_flag and evt_cnt to 0; pos_edge, neg_edge and irq SHALL read 0 during reset.
REQ-029 A channel whose d_in is 1 at reset release SHALL report one pos_edge after the REQ-019 latency.
REQ-030 Reset asserted mid-filter or mid-pulse SHALL abort it; no edge SHALL be produced from pre-reset activity.

Verification
REQ-031 Defaults, mode[1:0]=01, d_in[0] 0->1 before E1 held -> pos_edge[0] high only in cycle after E6; evt_flag[0]=1, evt_cnt[0]=1 after E7; irq=1.
REQ-032 d_in[1] high 3 cycles then low, mode=11 -> no pos_edge/neg_edge, evt_cnt[1] stays 0; high 4 cycles -> one pos_edge then one neg_edge, evt_cnt[1]=2.
REQ-033 CNT_W=2, 5 rising events on channel 2, mode=01 -> evt_cnt[2] sequence 1,2,3,3,3.
REQ-034 clr[3] asserted in the same cycle evt_flag[3] would set -> evt_flag[3]=1, evt_cnt[3]=1; clr[3] alone next -> both 0, irq drops if no other flags.
REQ-035 mode=00 on channel 4 with toggling input -> pos/neg_edge pulse, evt_flag[4]=0, evt_cnt[4]=0.
REQ-036 d_in=8'hFF held through reset release -> pos_edge=8'hFF for one cycle at REQ-019 latency; reset mid-filter on toggling input -> all outputs 0, no spurious pulse.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel input edge detector: synchroniser, glitch filter, edge pulses, mode-qualified sticky flags and saturating counters.
// Latency d_in -> pulse is SYNC_STAGES+FILT edges; no backpressure, every accepted transition is recorded.
module edge_detect_multi #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH-1:0]        d_in,
  input  logic [2*CH-1:0]      mode,
  input  logic [CH-1:0]        clr,
  output logic [CH-1:0]        pos_edge,
  output logic [CH-1:0]        neg_edge,
  output logic [CH-1:0]        evt_flag,
  output logic [CH*CNT_W-1:0]  evt_cnt,
  output logic                 irq
);

  localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CH-1:0] f;
  logic [CH-1:0] f_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [FCW-1:0]         fc;
    logic [CNT_W-1:0]       cnt;
    logic                   flag;
    logic                   s;
    logic                   qual;

    assign s    = sync[SYNC_STAGES-1];
    assign qual = (pos_edge[i] & mode[2*i]) | (neg_edge[i] & mode[2*i+1]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync   <= '0;
        fc     <= '0;
        f[i]   <= 1'b0;
        f_d[i] <= 1'b0;
      end else begin
        sync   <= {sync[SYNC_STAGES-2:0], d_in[i]};
        f_d[i] <= f[i];
        if (s == f[i]) begin
          fc <= '0;
        end else if (fc == FC_LAST) begin
          f[i] <= s;
          fc   <= '0;
        end else begin
          fc <= fc + FCW'(1);
        end
      end
    end

    // A clear coinciding with an event restarts the count at that event.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flag <= 1'b0;
        cnt  <= '0;
      end else if (clr[i]) begin
        flag <= qual;
        cnt  <= qual ? CNT_ONE : '0;
      end else if (qual) begin
        flag <= 1'b1;
        if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end
    end

    assign evt_flag[i]                  = flag;
    assign evt_cnt[i*CNT_W +: CNT_W]    = cnt;
  end

  assign pos_edge = f & ~f_d;
  assign neg_edge = ~f & f_d;
  assign irq      = |evt_flag;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a default instance plus a CNT_W=2 instance sharing stimulus.
module tb_edge_detect_multi;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  d_in;
  logic [15:0] mode;
  logic [7:0]  clr;
  logic [7:0]  pos_edge, neg_edge, evt_flag;
  logic [63:0] evt_cnt;
  logic        irq;
  logic [7:0]  pos2, neg2, flag2;
  logic [15:0] cnt2;
  logic        irq2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edge_detect_multi dut (
    .clk(clk), .reset(reset), .d_in(d_in), .mode(mode), .clr(clr),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .evt_flag(evt_flag),
    .evt_cnt(evt_cnt), .irq(irq)
  );

  edge_detect_multi #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .d_in(d_in), .mode(mode), .clr(clr),
    .pos_edge(pos2), .neg_edge(neg2), .evt_flag(flag2),
    .evt_cnt(cnt2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt_of(input int ch);
    return evt_cnt[ch*8 +: 8];
  endfunction

  int np, nn;
  logic [7:0] seen;

  initial begin
    reset = 1'b1; d_in = '0; mode = '0; clr = '0;
    #3;
    check("rst_pos", pos_edge, 8'h00);
    check("rst_neg", neg_edge, 8'h00);
    check("rst_flag", evt_flag, 8'h00);
    check("rst_cnt", evt_cnt, 64'h0);
    check("rst_irq", irq, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // Rising edge latency on channel 0
    mode[1:0] = 2'b01;
    d_in[0] = 1'b1;
    seen = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      seen |= pos_edge;
    end
    check("lat_early", seen[0], 1'b0);
    tick();
    check("lat_e6_pos", pos_edge[0], 1'b1);
    check("lat_e6_flag", evt_flag[0], 1'b0);
    tick();
    check("lat_e7_pos", pos_edge[0], 1'b0);
    check("lat_e7_flag", evt_flag[0], 1'b1);
    check("lat_e7_cnt", cnt_of(0), 8'd1);
    check("lat_e7_irq", irq, 1'b1);
    clr = 8'h01; tick(); clr = '0;
    check("clr0_flag", evt_flag[0], 1'b0);
    check("clr0_irq", irq, 1'b0);

    // Glitch filter on channel 1
    mode[3:2] = 2'b11;
    d_in[1] = 1'b1;
    tick(); tick(); tick();
    d_in[1] = 1'b0;
    np = 0; nn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      np += int'(pos_edge[1]); nn += int'(neg_edge[1]);
    end
    check("glitch3_pos", np, 0);
    check("glitch3_neg", nn, 0);
    check("glitch3_cnt", cnt_of(1), 8'd0);
    d_in[1] = 1'b1;
    tick(); tick(); tick(); tick();
    d_in[1] = 1'b0;
    np = 0; nn = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      np += int'(pos_edge[1]); nn += int'(neg_edge[1]);
    end
    check("pulse4_pos", np, 1);
    check("pulse4_neg", nn, 1);
    check("pulse4_cnt", cnt_of(1), 8'd2);

    // Saturation on channel 2 (CNT_W=2 in dut2)
    mode[5:4] = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      d_in[2] = 1'b1;
      repeat (8) tick();
      d_in[2] = 1'b0;
      repeat (8) tick();
      check($sformatf("sat2_ev%0d", k), cnt2[5:4], (k > 3) ? 2'd3 : 2'(k));
      check($sformatf("cnt8_ev%0d", k), cnt_of(2), 8'(k));
    end

    // Clear coincident with event, then clear alone, on channel 3
    clr = 8'hFF; tick(); clr = '0;
    check("clrall_flag", evt_flag, 8'h00);
    mode[7:6] = 2'b01;
    d_in[3] = 1'b1;
    repeat (6) tick();
    check("coinc_pos", pos_edge[3], 1'b1);
    clr = 8'h08; tick(); clr = '0;
    check("coinc_flag", evt_flag[3], 1'b1);
    check("coinc_cnt", cnt_of(3), 8'd1);
    check("coinc_irq", irq, 1'b1);
    clr = 8'h08; tick(); clr = '0;
    check("clr3_flag", evt_flag[3], 1'b0);
    check("clr3_cnt", cnt_of(3), 8'd0);
    check("clr3_irq", irq, 1'b0);

    // Mode off on channel 4: edges still pulse, nothing recorded
    mode[9:8] = 2'b00;
    np = 0; nn = 0;
    for (int k = 0; k < 2; k++) begin
      d_in[4] = 1'b1;
      repeat (8) begin tick(); np += int'(pos_edge[4]); nn += int'(neg_edge[4]); end
      d_in[4] = 1'b0;
      repeat (8) begin tick(); np += int'(pos_edge[4]); nn += int'(neg_edge[4]); end
    end
    check("off_pos", np, 2);
    check("off_neg", nn, 2);
    check("off_flag", evt_flag[4], 1'b0);
    check("off_cnt", cnt_of(4), 8'd0);

    // All-high inputs through reset release
    reset = 1'b1;
    d_in = 8'hFF;
    #1;
    check("rst2_pos", pos_edge, 8'h00);
    check("rst2_irq", irq, 1'b0);
    check("rst2_cnt", evt_cnt, 64'h0);
    tick(); tick();
    reset = 1'b0;
    seen = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      seen |= pos_edge;
    end
    check("ff_early", seen, 8'h00);
    tick();
    check("ff_e6", pos_edge, 8'hFF);
    tick();
    check("ff_e7", pos_edge, 8'h00);

    // Reset mid-filter aborts a pending fall
    d_in = 8'h00;
    tick(); tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("mid_pos", pos_edge, 8'h00);
    check("mid_neg", neg_edge, 8'h00);
    check("mid_flag", evt_flag, 8'h00);
    d_in = 8'h55; tick(); d_in = 8'h00; tick();
    reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      seen |= pos_edge | neg_edge;
    end
    check("mid_nopulse", seen, 8'h00);
    check("mid_irq", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
